phase_sweep_ctrl: RTL and testbench
===================================

// Module: phase_sweep_ctrl
// PURPOSE
//  Sequences one phase_calc instance over all array elements for one beam command (az, el, tx/rx).
//  Per element: fetches x/y offsets from the element table, issues pipelined phase_calc starts,
//  and writes the returned 6-bit phase index to the beam-weight RAM in element order.
//  Sits between the beam command interface and phase_calc / weight RAM.
// PARAMETERS
//  N_ELEM     64  elements per sweep (>=2); EAW = $clog2(N_ELEM)
//  ISSUE_GAP  2   cycles between consecutive pc_start pulses (>=2: table read + issue)
//  MAX_OUT    32  max starts in flight without a returned pc_valid (>=1)
//  TIMEOUT    64  cycles without pc_valid, while outstanding>0, before abort-with-error
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    async active-low reset
//  cmd_valid    in   1    beam command request
//  cmd_ready    out  1    high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_az       in   16   Q9.7 deg, latched on accept
//  cmd_el       in   16   Q9.7 deg, latched on accept
//  cmd_is_tx    in   1    1 = TX constant set, latched on accept
//  cmd_abort    in   1    stop issuing, drain, discard results
//  tbl_rd_en    out  1    element table read strobe (1-cycle read latency)
//  tbl_addr     out  EAW  element index to read
//  tbl_x        in   16   Q9.7 mm, valid cycle after tbl_rd_en
//  tbl_y        in   16   Q9.7 mm, valid cycle after tbl_rd_en
//  pc_start     out  1    1-cycle start to phase_calc
//  pc_is_tx / pc_az / pc_el / pc_x / pc_y  out  1/16/16/16/16  phase_calc operands, valid with pc_start
//  pc_valid     in   1    phase_calc result strobe (in-order)
//  pc_phase_idx in   6    phase_calc result
//  wr_en        out  1    weight RAM write
//  wr_addr      out  EAW  result element index
//  wr_data      out  6    = pc_phase_idx
//  busy         out  1    state != IDLE
//  done         out  1    1-cycle pulse at sweep end
//  status       out  2    00 ok, 01 aborted, 10 timeout; updated with done, held until next done
//  err_stray    out  1    sticky: pc_valid seen with outstanding==0; cleared on cmd accept
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE; counters cleared.
//  FSM: IDLE -> ISSUE (accept) -> DRAIN (all N_ELEM issued, or abort/timeout) -> DONE (outstanding==0) -> IDLE.
//  Accept at cycle T: az/el/is_tx latched; issue_idx=0, ret_idx=0, outstanding=0.
//  ISSUE slot: tbl_rd_en with tbl_addr=issue_idx at slot cycle S; pc_start with table data at S+1.
//    First read at T+1, first pc_start at T+2; next slot S+ISSUE_GAP.
//    Slot held (no read) while outstanding==MAX_OUT; resumes on first free cycle.
//  pc_az/pc_el/pc_is_tx = latched cmd values, constant for whole sweep.
//  Outstanding: +1 on pc_start, -1 on pc_valid; both in same cycle -> unchanged.
//  Return (pc_valid, outstanding>0): wr_en=1 same cycle (combinational from pc_valid, registered data path
//    not required), wr_addr=ret_idx, wr_data=pc_phase_idx; ret_idx++ saturating at N_ELEM-1.
//  Aborted/timed-out sweep: remaining returns drained but wr_en suppressed.
//  pc_valid with outstanding==0: ignored (no write, no underflow), err_stray=1.
//  cmd_abort in ISSUE: no further tbl_rd_en; a read already issued still gets its pc_start (no orphan
//    read); -> DRAIN; status 01. cmd_abort in DRAIN/DONE/IDLE: no effect except suppressing writes in DRAIN.
//  Timeout: wd counter resets on pc_valid or outstanding==0; reaching TIMEOUT -> outstanding forced 0,
//    status 10, -> DONE. Late pc_valid afterwards -> err_stray.
//  DONE: done=1 one cycle, status updated, -> IDLE. cmd_valid ignored outside IDLE.
//  rst_n low mid-sweep: immediate return to reset values; in-flight results lost.
// TESTING
//  1 Reset: rst_n low -> cmd_ready=1, busy=0, all strobes 0, status=00.
//  2 Full sweep, N=64, GAP=2, model latency 33: accept at T -> pc_start at T+2,T+4,..,T+128;
//    64 writes addr 0..63 in order; done one cycle after write 63; status=00.
//  3 Backpressure, MAX_OUT=4, latency 33: at most 4 pc_start before first pc_valid; all 64 writes.
//  4 Abort after 10 starts: no further tbl_rd_en; in-flight returns cause no wr_en; done, status=01.
//  5 Model drops result 5: no pc_valid for 64 cycles -> done, status=10; late pc_valid -> err_stray=1.
//  6 pc_valid in IDLE -> err_stray=1, no wr_en; next cmd accept clears err_stray.

Source files
------------

// File: rtl/phase_sweep_ctrl.sv
// Sweeps one phase_calc over every array element for a beam command and writes results in element order.
// Latency: first table read one cycle after accept, issue every ISSUE_GAP cycles; stalls at MAX_OUT in flight.
module phase_sweep_ctrl #(
  parameter int N_ELEM    = 64,
  parameter int ISSUE_GAP = 2,
  parameter int MAX_OUT   = 32,
  parameter int TIMEOUT   = 64,
  localparam int EAW      = $clog2(N_ELEM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [15:0]    cmd_az,
  input  logic [15:0]    cmd_el,
  input  logic           cmd_is_tx,
  input  logic           cmd_abort,
  output logic           tbl_rd_en,
  output logic [EAW-1:0] tbl_addr,
  input  logic [15:0]    tbl_x,
  input  logic [15:0]    tbl_y,
  output logic           pc_start,
  output logic           pc_is_tx,
  output logic [15:0]    pc_az,
  output logic [15:0]    pc_el,
  output logic [15:0]    pc_x,
  output logic [15:0]    pc_y,
  input  logic           pc_valid,
  input  logic [5:0]     pc_phase_idx,
  output logic           wr_en,
  output logic [EAW-1:0] wr_addr,
  output logic [5:0]     wr_data,
  output logic           busy,
  output logic           done,
  output logic [1:0]     status,
  output logic           err_stray
);

  localparam int OW = $clog2(MAX_OUT + 2);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(ISSUE_GAP + 1);
  localparam logic [EAW-1:0] LAST = EAW'(N_ELEM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [15:0]    az_q, el_q;
  logic           tx_q;
  logic [EAW-1:0] issue_idx, ret_idx;
  logic [OW-1:0]  outstanding, out_nxt;
  logic [OW:0]    occ;
  logic [GW-1:0]  gap_cnt;
  logic [WW-1:0]  wd_cnt;
  logic           rd_pending, aborted, err_q;
  logic [1:0]     status_q, status_nxt;
  logic           accept, ret_ok, stray, active, wd_hit, rd_en, last_rd;

  always_comb begin
    accept     = cmd_valid && (state == S_IDLE);
    active     = (state == S_ISSUE) || (state == S_DRAIN);
    ret_ok     = pc_valid && (outstanding != '0);
    stray      = pc_valid && (outstanding == '0);
    wd_hit     = active && (outstanding != '0) && !pc_valid && (wd_cnt == WW'(TIMEOUT - 1));
    // A read issued last cycle becomes a start this cycle, so it already occupies a slot.
    occ        = {1'b0, outstanding} + {{OW{1'b0}}, rd_pending};
    rd_en      = (state == S_ISSUE) && (gap_cnt == '0) && (occ < (OW + 1)'(MAX_OUT))
                 && !cmd_abort && !wd_hit;
    last_rd    = rd_en && (issue_idx == LAST);
    out_nxt    = outstanding;
    if (wd_hit)
      out_nxt = '0;
    else if (rd_pending && !ret_ok)
      out_nxt = outstanding + OW'(1);
    else if (!rd_pending && ret_ok)
      out_nxt = outstanding - OW'(1);
    status_nxt = wd_hit ? 2'b10 : (aborted ? 2'b01 : 2'b00);
    state_nxt  = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (wd_hit)
          state_nxt = S_DONE;
        else if (cmd_abort || last_rd)
          state_nxt = S_DRAIN;
      end
      S_DRAIN: if (wd_hit || out_nxt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      az_q        <= '0;
      el_q        <= '0;
      tx_q        <= 1'b0;
      issue_idx   <= '0;
      ret_idx     <= '0;
      outstanding <= '0;
      rd_pending  <= 1'b0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      aborted     <= 1'b0;
      err_q       <= 1'b0;
      status_q    <= 2'b00;
    end else begin
      state      <= state_nxt;
      rd_pending <= rd_en;
      if (accept) begin
        az_q        <= cmd_az;
        el_q        <= cmd_el;
        tx_q        <= cmd_is_tx;
        issue_idx   <= '0;
        ret_idx     <= '0;
        outstanding <= '0;
        gap_cnt     <= '0;
        aborted     <= 1'b0;
      end else begin
        outstanding <= out_nxt;
        if (rd_en && !last_rd)
          issue_idx <= issue_idx + EAW'(1);
        if (ret_ok && ret_idx != LAST)
          ret_idx <= ret_idx + EAW'(1);
        if (rd_en)
          gap_cnt <= GW'(ISSUE_GAP - 1);
        else if (gap_cnt != '0)
          gap_cnt <= gap_cnt - GW'(1);
        if (state == S_ISSUE && cmd_abort && !wd_hit)
          aborted <= 1'b1;
      end
      if (accept || pc_valid || outstanding == '0 || wd_hit || !active)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WW'(1);
      // A stray in the accept cycle still wins so it is never lost.
      if (stray)
        err_q <= 1'b1;
      else if (accept)
        err_q <= 1'b0;
      if (state != S_DONE && state_nxt == S_DONE)
        status_q <= status_nxt;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign status    = status_q;
  assign err_stray = err_q;
  assign tbl_rd_en = rd_en;
  assign tbl_addr  = issue_idx;
  assign pc_start  = rd_pending;
  assign pc_is_tx  = tx_q;
  assign pc_az     = az_q;
  assign pc_el     = el_q;
  assign pc_x      = rd_pending ? tbl_x : '0;
  assign pc_y      = rd_pending ? tbl_y : '0;
  // Results of an aborted sweep are drained but never land in the weight RAM.
  assign wr_en     = ret_ok && !aborted && !(active && cmd_abort);
  assign wr_addr   = ret_idx;
  assign wr_data   = wr_en ? pc_phase_idx : '0;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Bench for phase_sweep_ctrl: table and phase_calc models, scoreboard of expected weight-RAM writes.
module tb_phase_sweep_ctrl;
  localparam int N   = 64;
  localparam int EAW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_is_tx = 1'b0, cmd_abort = 1'b0, inj_vld = 1'b0;
  logic [15:0] cmd_az = '0, cmd_el = '0;
  logic [15:0] tbl_x = '0, tbl_y = '0;
  logic        m_vld = 1'b0;
  logic [5:0]  m_phase = '0;
  logic        pc_valid;
  logic        sel = 1'b0;
  assign pc_valid = m_vld | inj_vld;

  logic [1:0]          cmd_ready_i, tbl_rd_en_i, pc_start_i, pc_is_tx_i, wr_en_i, busy_i, done_i, err_stray_i;
  logic [1:0][EAW-1:0] tbl_addr_i, wr_addr_i;
  logic [1:0][15:0]    pc_az_i, pc_el_i, pc_x_i, pc_y_i;
  logic [1:0][5:0]     wr_data_i;
  logic [1:0][1:0]     status_i;

  logic a_cmd_ready, a_tbl_rd_en, a_pc_start, a_pc_is_tx, a_wr_en, a_busy, a_done, a_err_stray;
  logic [EAW-1:0] a_tbl_addr, a_wr_addr;
  logic [15:0] a_pc_az, a_pc_el, a_pc_x, a_pc_y;
  logic [5:0]  a_wr_data;
  logic [1:0]  a_status;
  assign a_cmd_ready = cmd_ready_i[sel];
  assign a_tbl_rd_en = tbl_rd_en_i[sel];
  assign a_pc_start  = pc_start_i[sel];
  assign a_pc_is_tx  = pc_is_tx_i[sel];
  assign a_wr_en     = wr_en_i[sel];
  assign a_busy      = busy_i[sel];
  assign a_done      = done_i[sel];
  assign a_err_stray = err_stray_i[sel];
  assign a_tbl_addr  = tbl_addr_i[sel];
  assign a_wr_addr   = wr_addr_i[sel];
  assign a_pc_az     = pc_az_i[sel];
  assign a_pc_el     = pc_el_i[sel];
  assign a_pc_x      = pc_x_i[sel];
  assign a_pc_y      = pc_y_i[sel];
  assign a_wr_data   = wr_data_i[sel];
  assign a_status    = status_i[sel];

  phase_sweep_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready_i[0]),
    .cmd_az(cmd_az), .cmd_el(cmd_el), .cmd_is_tx(cmd_is_tx), .cmd_abort(cmd_abort & ~sel),
    .tbl_rd_en(tbl_rd_en_i[0]), .tbl_addr(tbl_addr_i[0]), .tbl_x(tbl_x), .tbl_y(tbl_y),
    .pc_start(pc_start_i[0]), .pc_is_tx(pc_is_tx_i[0]), .pc_az(pc_az_i[0]), .pc_el(pc_el_i[0]),
    .pc_x(pc_x_i[0]), .pc_y(pc_y_i[0]), .pc_valid(pc_valid & ~sel), .pc_phase_idx(m_phase),
    .wr_en(wr_en_i[0]), .wr_addr(wr_addr_i[0]), .wr_data(wr_data_i[0]), .busy(busy_i[0]),
    .done(done_i[0]), .status(status_i[0]), .err_stray(err_stray_i[0])
  );

  phase_sweep_ctrl #(.MAX_OUT(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready_i[1]),
    .cmd_az(cmd_az), .cmd_el(cmd_el), .cmd_is_tx(cmd_is_tx), .cmd_abort(cmd_abort & sel),
    .tbl_rd_en(tbl_rd_en_i[1]), .tbl_addr(tbl_addr_i[1]), .tbl_x(tbl_x), .tbl_y(tbl_y),
    .pc_start(pc_start_i[1]), .pc_is_tx(pc_is_tx_i[1]), .pc_az(pc_az_i[1]), .pc_el(pc_el_i[1]),
    .pc_x(pc_x_i[1]), .pc_y(pc_y_i[1]), .pc_valid(pc_valid & sel), .pc_phase_idx(m_phase),
    .wr_en(wr_en_i[1]), .wr_addr(wr_addr_i[1]), .wr_data(wr_data_i[1]), .busy(busy_i[1]),
    .done(done_i[1]), .status(status_i[1]), .err_stray(err_stray_i[1])
  );

  function automatic logic [15:0] x_of(input int i);
    return 16'(i * 37 + 5);
  endfunction

  function automatic logic [15:0] y_of(input int i);
    return 16'(1000 - i * 11);
  endfunction

  function automatic logic [5:0] phase_fn(input logic tx, input logic [15:0] az, el, x, y);
    logic [15:0] h;
    h = az ^ {el[7:0], el[15:8]} ^ (x + y + y + y) ^ {15'd0, tx};
    return h[5:0] ^ h[11:6] ^ {2'b00, h[15:12]};
  endfunction

  // Element table (1-cycle read) and fixed-latency phase_calc with optional result dropping.
  typedef struct packed {logic [31:0] due; logic [5:0] ph;} ret_t;
  ret_t m_q[$];
  ret_t m_r;
  int   mcyc = 0, m_cnt = 0, lat = 33, drop_from = 1000;

  always @(posedge clk) begin
    mcyc <= mcyc + 1;
    if (a_tbl_rd_en) begin
      tbl_x <= x_of(int'(a_tbl_addr));
      tbl_y <= y_of(int'(a_tbl_addr));
    end
    if (cmd_valid && a_cmd_ready) begin
      m_q.delete();
      m_cnt <= 0;
    end else if (a_pc_start) begin
      if (m_cnt < drop_from) begin
        m_r.due = 32'(mcyc + lat);
        m_r.ph  = phase_fn(a_pc_is_tx, a_pc_az, a_pc_el, a_pc_x, a_pc_y);
        m_q.push_back(m_r);
      end
      m_cnt <= m_cnt + 1;
    end
    if (m_q.size() != 0 && m_q[0].due == 32'(mcyc + 1)) begin
      m_vld   <= 1'b1;
      m_phase <= m_q[0].ph;
      m_q.pop_front();
    end else begin
      m_vld   <= 1'b0;
      m_phase <= '0;
    end
  end

  typedef struct {int addr; int data;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0, mon_starts = 0, mon_reads = 0, rd_after_abort = 0;
  int n_wr = 0, n_unexp = 0, last_wr_cyc = 0, done_cyc = 0, done_status = 0;
  int tb_out = 0, peak = 0, sbfv = 0, es_post = 0;
  bit done_seen = 0, first_vld_seen = 0, abort_seen = 0, chk_timing = 0, expect_wr = 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (cmd_valid && a_cmd_ready) begin
      acc_cyc = cyc; mon_starts = 0; mon_reads = 0; rd_after_abort = 0; n_wr = 0; n_unexp = 0;
      tb_out = 0; peak = 0; first_vld_seen = 0; sbfv = 0;
      exp_q.delete();
    end
    if (cyc == acc_cyc + 1) es_post = int'(a_err_stray);
    if (a_tbl_rd_en) begin
      mon_reads++;
      if (abort_seen) rd_after_abort++;
    end
    if (pc_valid && !first_vld_seen) begin
      first_vld_seen = 1;
      sbfv = mon_starts;
    end
    if (a_pc_start) begin
      if (chk_timing) chk("start_cycle", cyc - acc_cyc, 2 + 2 * mon_starts);
      chk("pc_x", int'(a_pc_x), int'(x_of(mon_starts)));
      chk("pc_az", int'(a_pc_az), int'(cmd_az));
      if (expect_wr && mon_starts < drop_from) begin
        e.addr = mon_starts;
        e.data = int'(phase_fn(cmd_is_tx, cmd_az, cmd_el, x_of(mon_starts), y_of(mon_starts)));
        exp_q.push_back(e);
      end
      mon_starts++;
      tb_out++;
    end
    if (pc_valid && tb_out > 0) tb_out--;
    if (tb_out > peak) peak = tb_out;
    if (a_wr_en) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) n_unexp++;
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(a_wr_addr), e.addr);
        chk("wr_data", int'(a_wr_data), e.data);
      end
    end
    if (a_done) begin
      done_seen = 1;
      done_cyc = cyc;
      done_status = int'(a_status);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_sweep(input logic [15:0] az, input logic [15:0] el, input logic tx,
                           input int abort_n, input int budget);
    cmd_az = az; cmd_el = el; cmd_is_tx = tx;
    cmd_valid = 1'b1; abort_seen = 0; done_seen = 0;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < budget && !done_seen; k++) begin
      if (abort_n >= 0 && !abort_seen && mon_starts == abort_n) begin
        cmd_abort = 1'b1;
        abort_seen = 1;
      end
      tick();
      cmd_abort = 1'b0;
    end
    chk("done_seen", int'(done_seen), 1);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_cmd_ready", int'(a_cmd_ready), 1);
    chk("rst_cmd_ready_u1", int'(cmd_ready_i[1]), 1);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_strobes", int'({a_tbl_rd_en, a_pc_start, a_wr_en, a_done}), 0);
    chk("rst_status", int'(a_status), 0);
    chk("rst_err_stray", int'(a_err_stray), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stray result while idle
    inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    chk("idle_stray_err", int'(a_err_stray), 1);
    chk("idle_stray_no_wr", n_unexp, 0);

    // Full sweep with exact issue timing
    chk_timing = 1;
    run_sweep(16'h1234, 16'h0456, 1'b1, -1, 400);
    chk("full_err_cleared", es_post, 0);
    chk("full_starts", mon_starts, N);
    chk("full_writes", n_wr, N);
    chk("full_unexpected", n_unexp, 0);
    chk("full_exp_left", exp_q.size(), 0);
    chk("full_done_after_last_wr", done_cyc, last_wr_cyc + 1);
    chk("full_status", done_status, 0);
    tick();
    chk("full_idle_busy", int'(a_busy), 0);

    // Backpressure on the MAX_OUT=4 instance
    sel = 1'b1;
    chk_timing = 0;
    tick();
    run_sweep(16'hF0A5, 16'h3C00, 1'b0, -1, 1500);
    chk("bp_starts_before_ret", sbfv, 4);
    chk("bp_peak_outstanding", peak, 4);
    chk("bp_writes", n_wr, N);
    chk("bp_unexpected", n_unexp, 0);
    chk("bp_exp_left", exp_q.size(), 0);
    chk("bp_status", done_status, 0);

    // Abort after ten starts
    sel = 1'b0;
    chk_timing = 1;
    expect_wr = 0;
    tick();
    run_sweep(16'h0777, 16'h8001, 1'b0, 10, 400);
    chk("abort_reads", mon_reads, 10);
    chk("abort_rd_after", rd_after_abort, 0);
    chk("abort_starts", mon_starts, 10);
    chk("abort_writes", n_wr, 0);
    chk("abort_status", done_status, 1);

    // Timeout after a dropped result, then a late result
    chk_timing = 0;
    expect_wr = 1;
    drop_from = 5;
    tick();
    run_sweep(16'h2222, 16'h1111, 1'b1, -1, 600);
    chk("to_status", done_status, 2);
    chk("to_writes", n_wr, 5);
    chk("to_exp_left", exp_q.size(), 0);
    tick();
    chk("to_idle", int'(a_cmd_ready), 1);
    chk("to_err_before_late", int'(a_err_stray), 0);
    inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    chk("to_late_err_stray", int'(a_err_stray), 1);
    chk("to_late_no_wr", n_unexp, 0);
    chk("to_status_held", int'(a_status), 2);
    drop_from = 1000;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
